// File: rtl/dif_butterfly.sv
// Pipelined Gentleman-Sande (DIF) butterfly for the inverse NTT:
// A_out = (A+B) mod q, B_out = ((A-B)*W) mod q, with optional multiply-by-2^-1.

// Fixed-latency delay line for WIDTH-bit data.
module delay_n_cycles #(
  parameter int N     = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] taps_q [0:N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) taps_q[i] <= '0;
    end else begin
      taps_q[0] <= d;
      for (int i = 1; i < N; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign q = taps_q[N-1];
endmodule

// Pipelined modular multiplier p = a*b mod q (q odd, q < 2^(WIDTH-1), a,b < q).
// Interleaved MSB-first shift-and-add keeps the accumulator below q at every step,
// folding BPS multiplier bits per pipeline stage. Latency = WIDTH/BPS + 2 cycles.
module dif_modmult #(
  parameter int WIDTH = 32,
  parameter int BPS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] p
);
  localparam int NST = WIDTH / BPS;

  logic [WIDTH-1:0] a_q   [0:NST-1];
  logic [WIDTH-1:0] b_q   [0:NST-1];
  logic [WIDTH-1:0] acc_q [0:NST];
  logic [WIDTH-1:0] acc_d [0:NST-1];
  logic [WIDTH-1:0] p_q;

  // acc <- (2*acc + bit*a) mod q; both partial sums stay below 2q, so one
  // conditional subtraction after each step is enough.
  function automatic logic [WIDTH-1:0] mac_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] av,
                                                input logic [WIDTH-1:0] qv,
                                                input logic             bit_v);
    logic [WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, qv}) t = t - {1'b0, qv};
    if (bit_v) begin
      t = t + {1'b0, av};
      if (t >= {1'b0, qv}) t = t - {1'b0, qv};
    end
    return WIDTH'(t);
  endfunction

  always_comb begin
    for (int s = 0; s < NST; s++) begin
      logic [WIDTH-1:0] t;
      t = acc_q[s];
      for (int i = 0; i < BPS; i++) t = mac_step(t, a_q[s], q, b_q[s][WIDTH-1-i]);
      acc_d[s] = t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NST; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
      for (int s = 0; s <= NST; s++) acc_q[s] <= '0;
      p_q <= '0;
    end else begin
      a_q[0]   <= a;
      b_q[0]   <= b;
      acc_q[0] <= '0;
      for (int s = 0; s < NST - 1; s++) begin
        a_q[s+1] <= a_q[s];
        b_q[s+1] <= b_q[s] << BPS;
      end
      for (int s = 0; s < NST; s++) acc_q[s+1] <= acc_d[s];
      p_q <= acc_q[NST];
    end
  end

  assign p = p_q;
endmodule

module dif_butterfly #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             halve,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             busy
);
  // Valid-only streaming: a sample is taken on every rising edge with in_valid=1
  // and leaves exactly once with out_valid=1; there is no ready, so the consumer
  // must take every out_valid pulse.
  localparam int BPS          = 4;
  localparam int INTMUL_DELAY = WIDTH / BPS;
  localparam int MODRED_DELAY = 1;
  localparam int MODMUL_DELAY = INTMUL_DELAY + MODRED_DELAY + 1;

  logic [WIDTH:0]   q_ext, sum_w, diff_w;
  logic [WIDTH-1:0] sum_d, diff_d, mult_in_d;

  logic [WIDTH-1:0] s1_sum_q, s1_mult_q, s1_w_q;
  logic             s1_halve_q, s1_mode_q, s1_valid_q;

  logic [MODMUL_DELAY-1:0] valid_sr_q, halve_sr_q;
  logic [WIDTH-1:0]        sum_in, sum_dly, prod;
  logic                    v_out, h_out;

  logic [WIDTH-1:0] a_out_q, b_out_q, a_out_d, b_out_d;
  logic             out_valid_q;

  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] qv);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, qv}) : {1'b0, x};
    return WIDTH'(t >> 1);
  endfunction

  always_comb begin
    q_ext     = {1'b0, modulus};
    sum_w     = {1'b0, A} + {1'b0, B};
    sum_d     = (sum_w >= q_ext) ? WIDTH'(sum_w - q_ext) : WIDTH'(sum_w);
    diff_w    = {1'b0, A} - {1'b0, B};
    diff_d    = diff_w[WIDTH] ? WIDTH'(diff_w + q_ext) : diff_w[WIDTH-1:0];
    mult_in_d = mode ? A : diff_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_sum_q   <= '0;
      s1_mult_q  <= '0;
      s1_w_q     <= '0;
      s1_halve_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_sum_q   <= sum_d;
      s1_mult_q  <= mult_in_d;
      s1_w_q     <= W;
      s1_halve_q <= halve;
      s1_mode_q  <= mode;
      s1_valid_q <= in_valid;
    end
  end

  dif_modmult #(.WIDTH(WIDTH), .BPS(BPS)) u_modmult (
    .clk (clk),
    .rst (~reset),
    .a   (s1_mult_q),
    .b   (s1_w_q),
    .q   (modulus),
    .p   (prod)
  );

  // Multiply-only mode reports A_out = 0, so the side path carries zero.
  assign sum_in = s1_mode_q ? '0 : s1_sum_q;

  delay_n_cycles #(.N(MODMUL_DELAY), .WIDTH(WIDTH)) u_sum_dly (
    .clk   (clk),
    .rst_n (reset),
    .d     (sum_in),
    .q     (sum_dly)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_sr_q <= '0;
      halve_sr_q <= '0;
    end else begin
      valid_sr_q <= {valid_sr_q[MODMUL_DELAY-2:0], s1_valid_q};
      halve_sr_q <= {halve_sr_q[MODMUL_DELAY-2:0], s1_halve_q};
    end
  end

  assign v_out = valid_sr_q[MODMUL_DELAY-1];
  assign h_out = halve_sr_q[MODMUL_DELAY-1];

  always_comb begin
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    if (v_out) begin
      a_out_d = h_out ? halve_mod(sum_dly, modulus) : sum_dly;
      b_out_d = h_out ? halve_mod(prod, modulus) : prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= v_out;
    end
  end

  assign A_out     = a_out_q;
  assign B_out     = b_out_q;
  assign out_valid = out_valid_q;
  assign busy      = s1_valid_q | (|valid_sr_q);
endmodule

// File: tb/tb_dif_butterfly.sv
// Self-checking bench for dif_butterfly: directed vectors, a random stream with
// gaps checked by a scoreboard, and reset while samples are in flight.
module tb_dif_butterfly;
  localparam int WIDTH = 32;
  localparam int L     = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0, mode = 1'b0, halve = 1'b0;
  logic [WIDTH-1:0] A = '0, B = '0, W = '0, modulus = 32'd97;
  logic             out_valid, busy;
  logic [WIDTH-1:0] A_out, B_out;

  dif_butterfly #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mode      (mode),
    .halve     (halve),
    .A         (A),
    .B         (B),
    .W         (W),
    .modulus   (modulus),
    .out_valid (out_valid),
    .A_out     (A_out),
    .B_out     (B_out),
    .busy      (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] exp_e;
  bit                 vin_hist [0:8191];
  bit                 mon_en = 1'b0;
  logic [WIDTH-1:0]   last_a = '0, last_b = '0;
  int                 n_checks = 0, n_fail = 0;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, b, w, q,
                                               input logic md, hv);
    longint unsigned aa, bb, ww, qq, ao, bo, inv2;
    aa = a; bb = b; ww = w; qq = q;
    if (md) begin
      ao = 0;
      bo = (aa * ww) % qq;
    end else begin
      ao = (aa + bb) % qq;
      bo = (((aa + qq - bb) % qq) * ww) % qq;
    end
    if (hv) begin
      inv2 = (qq + 1) / 2;
      ao = (ao * inv2) % qq;
      bo = (bo * inv2) % qq;
    end
    return {ao[WIDTH-1:0], bo[WIDTH-1:0]};
  endfunction

  // Monitor: out_valid pattern, in-order results, hold during gaps
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (out_valid !== ((cyc >= L) ? vin_hist[cyc-L] : 1'b0)) begin
        n_fail++;
        $display("FAIL sb_valid_pattern cyc=%0d got=%b want=%b", cyc, out_valid,
                 (cyc >= L) ? vin_hist[cyc-L] : 1'b0);
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow cyc=%0d got A_out=%0d B_out=%0d want none", cyc, A_out, B_out);
        end else begin
          exp_e = exp_q.pop_front();
          if (A_out !== exp_e[2*WIDTH-1:WIDTH] || B_out !== exp_e[WIDTH-1:0]) begin
            n_fail++;
            $display("FAIL sb_result cyc=%0d got %0d/%0d want %0d/%0d", cyc, A_out, B_out,
                     exp_e[2*WIDTH-1:WIDTH], exp_e[WIDTH-1:0]);
          end
          last_a = exp_e[2*WIDTH-1:WIDTH];
          last_b = exp_e[WIDTH-1:0];
        end
      end else begin
        n_checks++;
        if (A_out !== last_a || B_out !== last_b) begin
          n_fail++;
          $display("FAIL sb_hold cyc=%0d got %0d/%0d want %0d/%0d", cyc, A_out, B_out, last_a, last_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive(input logic [WIDTH-1:0] a, b, w, input logic md, hv);
    @(negedge clk);
    A = a; B = b; W = w; mode = md; halve = hv; in_valid = 1'b1;
    vin_hist[cyc] = 1'b1;
    exp_q.push_back(model(a, b, w, modulus, md, hv));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    vin_hist[cyc] = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (out_valid === 1'b1) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < L + 3; i++) idle();
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || A_out !== '0 || B_out !== '0) begin
      n_fail++;
      $display("FAIL reset_values got v=%b busy=%b A=%0d B=%0d want 0 0 0 0", out_valid, busy, A_out, B_out);
    end
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_latency_basic();
    modulus = 32'd97;
    drive(32'd10, 32'd5, 32'd3, 1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_before got=%b want=0", busy);
    end
    for (int i = 1; i <= L + 1; i++) begin
      idle();
      n_checks++;
      if (busy !== (i < L) || out_valid !== (i == L)) begin
        n_fail++;
        $display("FAIL latency step=%0d got busy=%b v=%b want busy=%b v=%b", i, busy, out_valid, i < L, i == L);
      end
      if (i == L) begin
        n_checks++;
        if (A_out !== 32'd15 || B_out !== 32'd15) begin
          n_fail++;
          $display("FAIL basic_values got %0d/%0d want 15/15", A_out, B_out);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit got;
    drive(32'd90, 32'd20, 32'd2, 1'b0, 1'b0);
    drive(32'd5, 32'd10, 32'd1, 1'b0, 1'b0);
    wait_valid(got);
    n_checks++;
    if (!got || A_out !== 32'd13 || B_out !== 32'd43) begin
      n_fail++;
      $display("FAIL wrap_sum got v=%b %0d/%0d want 1 13/43", got, A_out, B_out);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || A_out !== 32'd15 || B_out !== 32'd92) begin
      n_fail++;
      $display("FAIL wrap_diff got v=%b %0d/%0d want 1 15/92", out_valid, A_out, B_out);
    end
    drain();
  endtask

  task automatic test_halve();
    bit got;
    drive(32'd10, 32'd5, 32'd3, 1'b0, 1'b1);
    drive(32'd0, 32'd0, 32'd7, 1'b0, 1'b1);
    drive(32'd96, 32'd0, 32'd1, 1'b0, 1'b1);
    wait_valid(got);
    n_checks++;
    if (!got || A_out !== 32'd56 || B_out !== 32'd56) begin
      n_fail++;
      $display("FAIL halve_odd got v=%b %0d/%0d want 1 56/56", got, A_out, B_out);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || A_out !== 32'd0 || B_out !== 32'd0) begin
      n_fail++;
      $display("FAIL halve_zero got v=%b %0d/%0d want 1 0/0", out_valid, A_out, B_out);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || A_out !== 32'd48 || B_out !== 32'd48) begin
      n_fail++;
      $display("FAIL halve_qm1 got v=%b %0d/%0d want 1 48/48", out_valid, A_out, B_out);
    end
    drain();
  endtask

  task automatic test_mult_mode();
    bit got;
    drive(32'd50, 32'd77, 32'd4, 1'b1, 1'b0);
    wait_valid(got);
    n_checks++;
    if (!got || A_out !== 32'd0 || B_out !== 32'd6) begin
      n_fail++;
      $display("FAIL mult_mode got v=%b %0d/%0d want 1 0/6", got, A_out, B_out);
    end
    drain();
  endtask

  task automatic test_boundary();
    bit got;
    drive(32'd33, 32'd33, 32'd5, 1'b0, 1'b0);
    drive(32'd40, 32'd57, 32'd2, 1'b0, 1'b0);
    drive(32'd0, 32'd5, 32'd1, 1'b0, 1'b0);
    wait_valid(got);
    n_checks++;
    if (!got || A_out !== 32'd66 || B_out !== 32'd0) begin
      n_fail++;
      $display("FAIL bnd_a_eq_b got v=%b %0d/%0d want 1 66/0", got, A_out, B_out);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || A_out !== 32'd0 || B_out !== 32'd63) begin
      n_fail++;
      $display("FAIL bnd_sum_eq_q got v=%b %0d/%0d want 1 0/63", out_valid, A_out, B_out);
    end
    idle();
    n_checks++;
    if (out_valid !== 1'b1 || A_out !== 32'd5 || B_out !== 32'd92) begin
      n_fail++;
      $display("FAIL bnd_a_zero got v=%b %0d/%0d want 1 5/92", out_valid, A_out, B_out);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int q;
    q = 12289;
    modulus = WIDTH'(q);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      drive(WIDTH'($urandom_range(0, q - 1)), WIDTH'($urandom_range(0, q - 1)),
            WIDTH'($urandom_range(0, q - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count got %0d leftover want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    modulus = 32'd97;
    drive(32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    drive(32'd4, 32'd5, 32'd6, 1'b0, 1'b0);
    drive(32'd7, 32'd8, 32'd9, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || A_out !== '0 || B_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear got busy=%b v=%b %0d/%0d want 0 0 0/0", busy, out_valid, A_out, B_out);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8192; i++) vin_hist[i] = 1'b0;
    last_a = '0;
    last_b = '0;
    mon_en = 1'b1;
    for (int i = 0; i < L + 2; i++) idle();
    drive(32'd10, 32'd5, 32'd3, 1'b0, 1'b0);
    for (int i = 1; i <= L; i++) begin
      idle();
      n_checks++;
      if (out_valid !== (i == L)) begin
        n_fail++;
        $display("FAIL midreset_latency step=%0d got v=%b want %b", i, out_valid, i == L);
      end
    end
    n_checks++;
    if (A_out !== 32'd15 || B_out !== 32'd15) begin
      n_fail++;
      $display("FAIL midreset_value got %0d/%0d want 15/15", A_out, B_out);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency_basic();
    test_wrap();
    test_halve();
    test_mult_mode();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue got %0d leftover want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dif_butterfly.md
# dif_butterfly

Pipelined Gentleman-Sande (decimation-in-frequency) butterfly for the inverse NTT datapath. It computes A_out = (A + B) mod q and B_out = ((A − B)·W) mod q, and can apply an optional multiply-by-2⁻¹ so the final INTT scaling needs no separate pass. A per-sample valid pipeline runs alongside the data, so the block accepts one butterfly per cycle and flags each result. It is the inverse-direction counterpart of the forward DIT butterfly and drops into the same memory/address-generator framework.

## Interface
- WIDTH, 32, data, twiddle and modulus width
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  A/B/W/mode/halve are sampled this cycle
- mode  input  1  0 = butterfly; 1 = multiply only (B_out = A·W mod q)
- halve  input  1  1 = multiply both results by 2⁻¹ mod q
- A  input  WIDTH  upper operand, < modulus
- B  input  WIDTH  lower operand, < modulus
- W  input  WIDTH  twiddle, < modulus
- modulus  input  WIDTH  odd q, < 2^(WIDTH−1); must stay constant while busy=1
- out_valid  output  1  A_out/B_out carry a new result this cycle
- A_out  output  WIDTH  (A+B) mod q, optionally halved; 0 in multiply mode
- B_out  output  WIDTH  ((A−B)·W) mod q (or A·W mod q in multiply mode), optionally halved
- busy  output  1  OR of all in-flight valid bits

## Operation
- **Stage S1 (registered).**
  - sum = A+B computed at WIDTH+1 bits; subtract q if ≥ q.
  - diff = A−B; add q if the result is negative.
  - mult_in = mode ? A : diff.
  - Registered into S1 together with W, halve, mode and in_valid.
- **Multiplier.**
  - Existing ModMult instance, A = mult_in, B = W, q = modulus.
  - Its reset input is driven by ~reset.
  - Latency MODMUL_DELAY = `INTMUL_DELAY + `MODRED_DELAY + 1 cycles.
- **Side path.**
  - The sum goes through delay_n_cycles (N = MODMUL_DELAY); its input is forced to 0 when mode=1.
  - halve and valid travel in a MODMUL_DELAY-deep shift register.
- **Output stage (registered).**
  - halve=0: pass values through.
  - halve=1: each value x becomes x[0] ? (x+q)>>1 : x>>1, computed at WIDTH+1 bits.
- **Output update rules.**
  - A_out/B_out update only when the valid bit reaching the output stage is 1; otherwise they hold their last value.
  - out_valid equals that valid bit.
- **Reset.** reset=0 clears every valid bit, S1 and the output registers.
  - The contents of ModMult and the delay line are don't-care, because their valid bits are cleared.
- **No stall or backpressure.** The consumer must accept every out_valid pulse.

## Timing
- Latency L = MODMUL_DELAY + 2: input sampled at edge k gives out_valid=1 after edge k+L.
- Throughput is one sample per cycle; back-to-back in_valid yields back-to-back out_valid in the same order.
- Reset values: out_valid=0, A_out=0, B_out=0, busy=0.
  - Outputs stay 0 until the first valid sample has propagated.
- Reset asserted mid-stream drops all in-flight samples: no out_valid after release until new in_valid plus L cycles.
- Gaps in in_valid appear as identical gaps in out_valid, with A_out/B_out holding their values.
- busy rises the cycle after the first accepted in_valid and falls L cycles after the last one.
- Boundary arithmetic:
  - A=B gives B_out=0.
  - A+B=q gives A_out=0.
  - A=0 and B≠0 gives diff = q−B.
  - halve of 0 is 0; halve of q−1 is (q−1)/2.

## Test plan
- q=97, A=10, B=5, W=3, mode=0, halve=0 → after exactly L cycles: out_valid=1, A_out=15, B_out=15.
- Wrap cases, q=97:
  - A=90, B=20, W=2 → A_out=13, B_out=43.
  - A=5, B=10, W=1 → A_out=15, B_out=92.
- Halving: first vector with halve=1 → A_out=56, B_out=56. Also A=0, B=0 → 0, 0.
- Multiply mode: A=50, B=77, W=4, mode=1 → A_out=0, B_out=6.
- Stream of 64 random back-to-back vectors with random single-cycle gaps; check against a software model (q = 12289, WIDTH=32):
  - order and count preserved;
  - out_valid pattern equals in_valid pattern delayed by L;
  - outputs hold during gaps.
- Assert reset for 1 cycle while 3 samples are in flight → those samples never produce out_valid; busy=0 and outputs are 0 immediately; a new sample after release appears L cycles later and is correct.
